// File: rtl/serial_alu.sv
// -----------------------------------------------------------------------------
// serial_alu
//
// Execution-stage ALU. Single-cycle arithmetic, logic, compare and jump-target
// operations; shifts are bit-serial (one bit per clock) behind a start/busy/done
// handshake so the core can stall while a shift runs.
//
// Build option:
//   SERIAL_ALU_BARREL_SHIFT_EN  - when defined, shifts use a combinational
//                                 barrel shifter, every op completes in one
//                                 edge and busy is tied low.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     operation request, accepted on a rising edge when busy=0
//   alu_sel   4-bit operation select from ALU control
//   a, b      operands (shift amount is b[SHAMT_W-1:0])
//   busy      high while a serial shift is in progress
//   done      one-cycle completion pulse
//   result    registered result, held between completions
//   zero      result == 0
//   carry     add carry-out / sub-compare "no borrow" (a >= b unsigned)
//   overflow  signed overflow for add/sub/compare
//   sign      result MSB
// -----------------------------------------------------------------------------
module serial_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             sign
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_BR   = 4'b0010;
    localparam logic [3:0] OP_JAL  = 4'b0011;
    localparam logic [3:0] OP_JALR = 4'b1011;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1111;
    localparam logic [3:0] OP_LUI  = 4'b0110;

    // Single-edge evaluation. Returns {overflow, carry, result}.
    // In the serial build a shift only reaches this function with amount 0,
    // so the shift cases simply pass operand A through and no barrel shifter
    // is built.
    function automatic logic [WIDTH+1:0] alu_eval(
        input logic [3:0]       sel,
        input logic [WIDTH-1:0] op_a,
        input logic [WIDTH-1:0] op_b
    );
        logic [WIDTH:0]   sum;
        logic [WIDTH:0]   diff;
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        logic             lt_s;
        logic             lt_u;
`ifdef SERIAL_ALU_BARREL_SHIFT_EN
        logic [SHAMT_W-1:0] sh;
        sh = op_b[SHAMT_W-1:0];
`endif
        sum  = {1'b0, op_a} + {1'b0, op_b};
        diff = {1'b0, op_a} - {1'b0, op_b};
        lt_s = $signed(op_a) < $signed(op_b);
        lt_u = op_a < op_b;
        res  = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (sel)
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB, OP_BR: begin
                res = diff[WIDTH-1:0];
                // diff[WIDTH] is the borrow; carry reports "no borrow".
                c   = ~diff[WIDTH];
                v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_JAL:  res = sum[WIDTH-1:0];
            OP_JALR: res = {sum[WIDTH-1:1], 1'b0};
            OP_AND:  res = op_a & op_b;
            OP_OR:   res = op_a | op_b;
            OP_XOR:  res = op_a ^ op_b;
`ifdef SERIAL_ALU_BARREL_SHIFT_EN
            OP_SRL:  res = op_a >> sh;
            OP_SRA:  res = $unsigned($signed(op_a) >>> sh);
            OP_SLL:  res = op_a << sh;
`else
            OP_SRL, OP_SRA, OP_SLL: res = op_a;
`endif
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, lt_u};
            OP_LUI:  res = op_b;
            default: res = '0;
        endcase
        return {v, c, res};
    endfunction

    logic [WIDTH+1:0] eval_p0;

    assign eval_p0 = alu_eval(alu_sel, a, b);
    assign zero    = (result == '0);
    assign sign    = result[WIDTH-1];

`ifdef SERIAL_ALU_BARREL_SHIFT_EN

    assign busy = 1'b0;

    // Stage 0 -> 1: every operation registers its result on the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= start;
            if (start) begin
                {overflow, carry, result} <= eval_p0;
            end
        end
    end

`else

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_shift;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         kind;
    logic               is_shift;
    logic               shamt_nz;
    logic               last_step;

    // Shift one bit. kind is alu_sel[1:0]: 00 SRL, 01 SLL, 10 SRA.
    function automatic logic [WIDTH-1:0] shift_one(
        input logic [1:0]       k,
        input logic [WIDTH-1:0] v
    );
        logic [WIDTH-1:0] r;
        case (k)
            2'b01:   r = {v[WIDTH-2:0], 1'b0};
            2'b10:   r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = {1'b0, v[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    assign is_shift  = (alu_sel == OP_SRL) || (alu_sel == OP_SRA) || (alu_sel == OP_SLL);
    assign shamt_nz  = |b[SHAMT_W-1:0];
    assign acc_shift = shift_one(kind, acc);
    assign last_step = (cnt == SHAMT_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. busy is low in IDLE, so start alone means acceptance.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && is_shift && shamt_nz) state_nxt = S_SHIFT;
            S_SHIFT: if (last_step) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy = (state == S_SHIFT);
    end

    // Stage 0 -> 1: accept, single-edge result or load of the shift engine.
    // Shift stages: one bit per edge until the counter reaches zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            kind     <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_shift && shamt_nz) begin
                            acc  <= a;
                            cnt  <= b[SHAMT_W-1:0];
                            kind <= alu_sel[1:0];
                        end else begin
                            {overflow, carry, result} <= eval_p0;
                            done <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    acc <= acc_shift;
                    cnt <= cnt - SHAMT_W'(1);
                    if (last_step) begin
                        result   <= acc_shift;
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`endif

endmodule
